alu_bcd_display: RTL

ALU_BCD_DISPLAY -- requirements
Module: alu_bcd_display

---
 rtl/alu_disp_pkg.sv | 18 +
 rtl/alu_bcd_display_if.sv | 23 ++
 rtl/alu_bcd_display_hex_decoder.sv | 27 ++
 rtl/alu_bcd_display.sv | 93 +++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result BCD display block.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         ITER  = 8;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 after the shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/alu_bcd_display_if.sv
// Request/result bundle between the ALU-side controller and the BCD display converter.
interface alu_bcd_display_if;

  logic        Start;
  logic [7:0]  Value;
  logic        Busy;
  logic        Done;
  logic [11:0] BCD;
  logic [6:0]  HEX2;
  logic [6:0]  HEX1;
  logic [6:0]  HEX0;

  modport master (
    output Start, Value,
    input  Busy, Done, BCD, HEX2, HEX1, HEX0
  );

  modport slave (
    input  Start, Value,
    output Busy, Done, BCD, HEX2, HEX1, HEX0
  );

endinterface

// File: rtl/alu_bcd_display_hex_decoder.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}; non-decimal codes go dark.
module hex_decoder
  import alu_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    seg_o = BLANK;
    unique case (digit_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = BLANK;
    endcase
  end

endmodule

// File: rtl/alu_bcd_display.sv
// Sequential double-dabble converter: 8-bit ALU result to three BCD digits with
// seven-segment decodes and optional leading-zero blanking.
module alu_bcd_display
  import alu_disp_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset_b,
  input  logic        Start,
  input  logic [7:0]  Value,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] BCD,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  state_e      state_q;
  logic [7:0]  bin_q;
  logic [11:0] scratch_q;
  logic [3:0]  count_q;
  logic [11:0] bcd_q;

  logic [7:0]  bin_d;
  logic [11:0] scratch_d;
  logic [11:0] adjusted;

  always_comb begin
    adjusted = {dabble_adj(scratch_q[11:8]),
                dabble_adj(scratch_q[7:4]),
                dabble_adj(scratch_q[3:0])};
    {scratch_d, bin_d} = {adjusted, bin_q} << 1;
  end

  // bcd_q is only written on the last iteration so partial scratch never reaches the display.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd_q     <= '0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            bin_q     <= Value;
            scratch_q <= '0;
            count_q   <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q     <= bin_d;
          scratch_q <= scratch_d;
          count_q   <= count_q + 4'd1;
          if (count_q == 4'(ITER - 1)) begin
            bcd_q   <= scratch_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign BCD  = bcd_q;

  logic [6:0] seg2, seg1, seg0;

  hex_decoder u_dec2 (.digit_i(bcd_q[11:8]), .seg_o(seg2));
  hex_decoder u_dec1 (.digit_i(bcd_q[7:4]),  .seg_o(seg1));
  hex_decoder u_dec0 (.digit_i(bcd_q[3:0]),  .seg_o(seg0));

  logic hund_zero, tens_zero;
  assign hund_zero = (bcd_q[11:8] == 4'd0);
  assign tens_zero = (bcd_q[7:4] == 4'd0);

  assign HEX2 = (LZ_BLANK && hund_zero)              ? BLANK : seg2;
  assign HEX1 = (LZ_BLANK && hund_zero && tens_zero) ? BLANK : seg1;
  assign HEX0 = seg0;

endmodule
